// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: FSM encoding and
// requester indices.
package sram_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int N_REQ = 2;
  localparam int REQ0  = 0;
  localparam int REQ1  = 1;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that was not granted last time wins.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last_gnt,
  output logic [N_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[REQ0] && req[REQ1]) begin
      if (last_gnt) gnt[REQ0] = 1'b1;
      else          gnt[REQ1] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Front end for a single-port registered-output SRAM: clears every word after
// reset, then shares the port round-robin between two requesters.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BIT_WIDTH  = 8
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [BIT_WIDTH-1:0]  r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [BIT_WIDTH-1:0]  r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [BIT_WIDTH-1:0]  r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [BIT_WIDTH-1:0]  r1_rdata,
  output logic                  init_busy,
  output logic                  mem_rst_n,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [BIT_WIDTH-1:0]  mem_dina,
  input  logic [BIT_WIDTH-1:0]  mem_douta
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  last_gnt;
  logic [N_REQ-1:0]      rvalid_q;
  logic [N_REQ-1:0]      req_vec;
  logic [N_REQ-1:0]      pick;
  logic [N_REQ-1:0]      gnt;

  assign req_vec = {r1_req, r0_req};

  rr_arb2 u_arb (
    .req      (req_vec),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // Grants only exist in RUN and are forced off during the reset cycle itself.
  always_comb begin
    state_next = state;
    gnt        = '0;
    mem_ena    = 1'b0;
    mem_wea    = 1'b0;
    mem_addra  = '0;
    mem_dina   = '0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          mem_ena   = 1'b1;
          mem_wea   = 1'b1;
          mem_addra = init_cnt;
          if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) state_next = ST_RUN;
        end
        ST_RUN: begin
          gnt = pick;
          if (gnt[REQ0]) begin
            mem_ena   = 1'b1;
            mem_wea   = r0_we;
            mem_addra = r0_addr;
            mem_dina  = r0_wdata;
          end else if (gnt[REQ1]) begin
            mem_ena   = 1'b1;
            mem_wea   = r1_we;
            mem_addra = r1_addr;
            mem_dina  = r1_wdata;
          end
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  // rvalid_q remembers which requester owns the read data arriving next cycle.
  always_ff @(posedge clka) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      last_gnt <= 1'b1;
      rvalid_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (|gnt) last_gnt <= gnt[REQ1];
      rvalid_q[REQ0] <= gnt[REQ0] & ~r0_we;
      rvalid_q[REQ1] <= gnt[REQ1] & ~r1_we;
    end
  end

  assign r0_gnt    = gnt[REQ0];
  assign r1_gnt    = gnt[REQ1];
  assign r0_rvalid = rvalid_q[REQ0] & ~rst;
  assign r1_rvalid = rvalid_q[REQ1] & ~rst;
  assign r0_rdata  = mem_douta;
  assign r1_rdata  = mem_douta;
  assign init_busy = rst | (state == ST_INIT);
  assign mem_rst_n = ~rst;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_sram_arbiter;

  localparam int AW    = 4;
  localparam int BW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clka = 1'b0;
  logic          rst  = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [BW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [BW-1:0] r0_rdata, r1_rdata;
  logic          init_busy, mem_rst_n, mem_ena, mem_wea;
  logic [AW-1:0] mem_addra;
  logic [BW-1:0] mem_dina, mem_douta;

  int checks   = 0;
  int failures = 0;

  sram_arbiter #(.ADDR_WIDTH(AW), .BIT_WIDTH(BW)) dut (
    .clka      (clka),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .init_busy (init_busy),
    .mem_rst_n (mem_rst_n),
    .mem_ena   (mem_ena),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_douta (mem_douta)
  );

  always #5 clka = ~clka;

  // Registered-output single-port SRAM with an active-low output reset.
  logic [BW-1:0] sram [DEPTH];
  always @(posedge clka) begin
    if (!mem_rst_n) mem_douta <= '0;
    else if (mem_ena) begin
      if (mem_wea) sram[mem_addra] <= mem_dina;
      else         mem_douta <= sram[mem_addra];
    end
  end

  // Behavioural model: the cleared-or-written contents, who won last, and
  // which read result is owed to whom on the following cycle.
  int            init_left = DEPTH;
  int            m_last = 1;
  logic [BW-1:0] m_mem [DEPTH];
  bit            pend_v [2];
  logic [BW-1:0] pend_d [2];
  int            exp_g = -1;

  logic          s_gnt0, s_gnt1, s_rvalid0, s_rvalid1, s_busy, s_wea, s_ena;
  logic [BW-1:0] s_rdata0, s_rdata1, s_din;
  logic [AW-1:0] s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    int            g;
    bit            rq [2];
    bit            we [2];
    logic [AW-1:0] ad [2];
    logic [BW-1:0] wd [2];
    s_gnt0 = r0_gnt;       s_gnt1 = r1_gnt;
    s_rvalid0 = r0_rvalid; s_rvalid1 = r1_rvalid;
    s_rdata0 = r0_rdata;   s_rdata1 = r1_rdata;
    s_busy = init_busy;    s_wea = mem_wea;  s_ena = mem_ena;
    s_addr = mem_addra;    s_din = mem_dina;
    rq[0] = r0_req; we[0] = r0_we; ad[0] = r0_addr; wd[0] = r0_wdata;
    rq[1] = r1_req; we[1] = r1_we; ad[1] = r1_addr; wd[1] = r1_wdata;
    exp_g = -1;
    if (rst) begin
      chk("rst_gnt0", s_gnt0, 0);
      chk("rst_gnt1", s_gnt1, 0);
      chk("rst_rvalid0", s_rvalid0, 0);
      chk("rst_rvalid1", s_rvalid1, 0);
      chk("rst_busy", s_busy, 1);
      chk("rst_mem_rst_n", mem_rst_n, 0);
      init_left = DEPTH;
      m_last    = 1;
      pend_v[0] = 0;
      pend_v[1] = 0;
    end else begin
      chk("mem_rst_n", mem_rst_n, 1);
      chk("rvalid0", s_rvalid0, pend_v[0]);
      chk("rvalid1", s_rvalid1, pend_v[1]);
      if (pend_v[0]) chk("rdata0", s_rdata0, pend_d[0]);
      if (pend_v[1]) chk("rdata1", s_rdata1, pend_d[1]);
      pend_v[0] = 0;
      pend_v[1] = 0;
      if (init_left > 0) begin
        chk("init_busy", s_busy, 1);
        chk("init_gnt0", s_gnt0, 0);
        chk("init_gnt1", s_gnt1, 0);
        chk("init_ena", s_ena, 1);
        chk("init_wea", s_wea, 1);
        chk("init_addr", s_addr, DEPTH - init_left);
        chk("init_din", s_din, 0);
        m_mem[DEPTH - init_left] = '0;
        init_left--;
      end else begin
        chk("run_busy", s_busy, 0);
        if (rq[0] && rq[1]) g = 1 - m_last;
        else if (rq[0])     g = 0;
        else if (rq[1])     g = 1;
        else                g = -1;
        exp_g = g;
        chk("gnt0", s_gnt0, g == 0);
        chk("gnt1", s_gnt1, g == 1);
        chk("mem_ena", s_ena, g >= 0);
        if (g >= 0) begin
          chk("mem_wea", s_wea, we[g]);
          chk("mem_addra", s_addr, ad[g]);
          if (we[g]) begin
            chk("mem_dina", s_din, wd[g]);
            m_mem[ad[g]] = wd[g];
          end else begin
            pend_v[g] = 1;
            pend_d[g] = m_mem[ad[g]];
          end
          m_last = g;
        end else begin
          chk("mem_wea_idle", s_wea, 0);
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clka);
    check_output();
    @(posedge clka);
    #1;
  endtask

  task automatic apply_stimulus(output logic req, output logic we,
                                output logic [AW-1:0] addr, output logic [BW-1:0] wd);
    req  = ($urandom_range(0, 3) != 0);
    we   = $urandom_range(0, 1);
    addr = AW'($urandom_range(0, DEPTH - 1));
    wd   = BW'($urandom);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    logic [BW-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;

    // Reset and idle clear sequence, then a read of a cleared word.
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("t1_busy", s_busy, 1);
      chk("t1_addr", s_addr, i);
      chk("t1_wea", s_wea, 1);
    end
    r0_req = 1; r0_we = 0; r0_addr = 4'd5;
    cycle();
    chk("t1_busy_done", s_busy, 0);
    chk("t1_gnt0", s_gnt0, 1);
    r0_req = 0;
    cycle();
    chk("t1_rvalid0", s_rvalid0, 1);
    chk("t1_rdata0", s_rdata0, 8'h00);

    // Write by r0 then immediate read by r1 of the same word.
    r0_req = 1; r0_we = 1; r0_addr = 4'd3; r0_wdata = 8'hA5;
    cycle();
    chk("t2_gnt0", s_gnt0, 1);
    r0_req = 0; r1_req = 1; r1_we = 0; r1_addr = 4'd3;
    cycle();
    chk("t2_gnt1", s_gnt1, 1);
    r1_req = 0;
    cycle();
    chk("t2_rvalid1", s_rvalid1, 1);
    chk("t2_rdata1", s_rdata1, 8'hA5);
    chk("t2_rvalid0", s_rvalid0, 0);

    // Continuous contention alternates, starting with r0 since r1 won last.
    r0_req = 1; r0_we = 0; r0_addr = 4'd2;
    r1_req = 1; r1_we = 0; r1_addr = 4'd3;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t3_gnt0", s_gnt0, (i % 2) == 0);
      chk("t3_gnt1", s_gnt1, (i % 2) == 1);
      if (i > 0) chk("t3_rvalid0", s_rvalid0, (i % 2) == 1);
    end
    r0_req = 0; r1_req = 0;
    cycle();

    // Back-to-back reads of preloaded words.
    for (int i = 0; i < 3; i++) begin
      r0_req = 1; r0_we = 1; r0_addr = AW'(i + 1); r0_wdata = vals[i];
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      r0_we = 0; r0_addr = AW'(i + 1);
      cycle();
      chk("t6_gnt0", s_gnt0, 1);
      if (i > 0) chk("t6_rdata0", s_rdata0, vals[i - 1]);
    end
    r0_req = 0;
    cycle();
    chk("t6_rvalid_last", s_rvalid0, 1);
    chk("t6_rdata_last", s_rdata0, 8'h33);

    // Reset after a granted read drops it and re-clears memory.
    r0_req = 1; r0_we = 1; r0_addr = 4'd7; r0_wdata = 8'h3C;
    cycle();
    r0_we = 0;
    cycle();
    chk("t5_gnt0", s_gnt0, 1);
    r0_req = 0; rst = 1;
    cycle();
    chk("t5_rvalid0", s_rvalid0, 0);
    chk("t5_busy", s_busy, 1);
    rst = 0;
    cycle();
    chk("t5_init_addr0", s_addr, 0);
    for (int i = 1; i < DEPTH; i++) cycle();
    r0_req = 1; r0_we = 0; r0_addr = 4'd7;
    cycle();
    r0_req = 0;
    cycle();
    chk("t5_rvalid0_after", s_rvalid0, 1);
    chk("t5_rdata0_cleared", s_rdata0, 8'h00);

    // Request held across reset waits out the whole clear sequence.
    r1_req = 1; r1_we = 0; r1_addr = 4'd9; rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("t4_gnt1_init", s_gnt1, 0);
    end
    cycle();
    chk("t4_gnt1_run", s_gnt1, 1);
    r1_req = 0;
    cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!rst) begin
        if (!r0_req || exp_g == 0) apply_stimulus(r0_req, r0_we, r0_addr, r0_wdata);
        if (!r1_req || exp_g == 1) apply_stimulus(r1_req, r1_we, r1_addr, r1_wdata);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
